keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad: drives rows one-hot active-low, samples the column returns and debounces whole-matrix snapshots.
- Publishes a 16-bit active-low key vector, index 4*row+col, 1 = released. This vector feeds the key remapping stage directly.
- Also emits a one-cycle press event carrying the encoded key index for the calculator/menu control logic.

Parameters:
- SCAN_DIV, 50000: clock cycles each row is driven (dwell); legal minimum 3.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan snapshots required before the snapshot is accepted; legal minimum 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scan_en  input  1  1 = scanning runs; 0 = scanner parked
- col_n  input  4  keypad column returns, active-low, asynchronous to clk
- row_n  output  4  row drive, one-hot active-low, 4'hF = no row driven
- key_state  output  16  debounced key vector, active-low, bit 4*r+c
- any_key  output  1  1 when any bit of key_state is 0
- key_press  output  1  one-cycle pulse on a newly accepted press
- key_code  output  4  index of reported key; valid with key_press, held otherwise

Behaviour:
- Reset (async assert, sync release): row_n=4'hF, key_state=16'hFFFF, any_key=0, key_press=0, key_code=0. Reset also clears all counters, the snapshot, the candidate and the stable count, and puts the FSM in IDLE.
- col_n passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, DRIVE, EVAL.
- IDLE:
  - row_n=4'hF.
  - Goes to DRIVE with row=0 and div_cnt=0 when scan_en=1.
- DRIVE:
  - row_n[row]=0, all other rows 1.
  - div_cnt counts 0..SCAN_DIV-1.
  - At div_cnt==SCAN_DIV-1, the synchronized col_n is written into snapshot[4*row+3:4*row] and div_cnt wraps to 0.
  - If row<3 then row+1; if row==3 go to EVAL.
- EVAL (exactly 1 cycle, row_n=4'hF):
  - If snapshot==candidate: stable_cnt+1, saturating at DEBOUNCE_SCANS.
  - Else: candidate<=snapshot and stable_cnt<=1.
  - If the resulting stable_cnt>=DEBOUNCE_SCANS, key_state<=candidate value in effect after this update.
  - Then go to DRIVE, row=0 (or IDLE if scan_en=0).
- Full scan period = 4*SCAN_DIV+1 cycles.
- Worst-case acceptance = DEBOUNCE_SCANS full scans after the key state stabilises, plus the partial current scan.
- Press event:
  - new = key_state_old & ~key_state_new (bits going 1 to 0).
  - If new != 0, key_press=1 for the one cycle after the key_state update, and key_code = lowest set index of new.
  - Further simultaneous new presses are not reported. Releases produce no event. A held key never re-pulses.
- any_key is registered with key_state (same cycle), equal to ~&key_state.
- scan_en=0 at any point:
  - Next cycle goes to IDLE, row_n=4'hF, and the partial snapshot is discarded.
  - candidate, stable_cnt and key_state are held.
  - Re-enable restarts at row 0, div_cnt 0.
- Ghosting and multi-key masking are not resolved. The raw matrix result is reported.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, scan period 17 cycles; bench keypad model pulls col_n[c]=0 while row_n[r]=0 and key (r,c) is held):
- Reset asserted mid-DRIVE -> same cycle row_n=4'hF and key_state=16'hFFFF; after release, IDLE until scan_en, then row_n sequence E,D,B,7 (4 cycles each), then F for 1 cycle, repeating.
- Hold key (1,2) from idle -> key_state=16'hFFBF after the second matching EVAL; exactly one key_press with key_code=6; any_key=1; no further pulses while held.
- Key (0,0) alternates pressed/released on successive scans -> key_state stays 16'hFFFF, key_press never asserts.
- Keys index 3 and 12 pressed in the same scan -> key_state=16'hEFF7, single key_press with key_code=3.
- Release after the key_state=16'hFFBF case -> key_state=16'hFFFF after 2 matching scans, any_key falls to 0, no key_press.
- scan_en dropped during row 2 with key 6 accepted -> row_n=4'hF next cycle and key_state held at 16'hFFBF; re-enable -> scan restarts at row 0 (row_n=4'hE).

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows one-hot active-low, debounces whole-matrix
// snapshots and reports the accepted key vector plus a single press event per new key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [15:0] key_state,
  output logic        any_key,
  output logic        key_press,
  output logic [3:0]  key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DB_MAX   = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DRIVE, EVAL} state_t;

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    row_n_q, row_n_d;
  logic [15:0]   key_state_q, key_state_d;
  logic          any_key_q, any_key_d;
  logic          key_press_q, key_press_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [3:0]    col_meta_q, col_sync_q;
  logic [15:0]   new_keys;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    div_d       = div_q;
    snap_d      = snap_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    key_state_d = key_state_q;
    any_key_d   = any_key_q;
    key_press_d = 1'b0;
    key_code_d  = key_code_q;
    new_keys    = '0;

    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = DRIVE;
          row_d   = '0;
          div_d   = '0;
        end
      end
      DRIVE: begin
        if (!scan_en) begin
          state_d = IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          snap_d[{row_q, 2'b00} +: 4] = col_sync_q;
          if (row_q == 2'd3) state_d = EVAL;
          else               row_d   = row_q + 2'd1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      EVAL: begin
        if (snap_q == cand_q) begin
          if (stable_q < DB_MAX) stable_d = stable_q + SW'(1);
        end else begin
          cand_d   = snap_q;
          stable_d = SW'(1);
        end
        // Only keys going released->pressed raise an event; the lowest index wins.
        if (stable_d >= DB_MAX) begin
          key_state_d = cand_d;
          any_key_d   = ~&cand_d;
          new_keys    = key_state_q & ~cand_d;
          if (|new_keys) begin
            key_press_d = 1'b1;
            for (int i = 15; i >= 0; i--) begin
              if (new_keys[i]) key_code_d = 4'(i);
            end
          end
        end
        state_d = scan_en ? DRIVE : IDLE;
        row_d   = '0;
        div_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    row_n_d = (state_d == DRIVE) ? ~(4'b0001 << row_d) : 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      div_q       <= '0;
      snap_q      <= '0;
      cand_q      <= '0;
      stable_q    <= '0;
      row_n_q     <= 4'hF;
      key_state_q <= 16'hFFFF;
      any_key_q   <= 1'b0;
      key_press_q <= 1'b0;
      key_code_q  <= '0;
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      div_q       <= div_d;
      snap_q      <= snap_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      row_n_q     <= row_n_d;
      key_state_q <= key_state_d;
      any_key_q   <= any_key_d;
      key_press_q <= key_press_d;
      key_code_q  <= key_code_d;
      col_meta_q  <= col_n;
      col_sync_q  <= col_meta_q;
    end
  end

  assign row_n     = row_n_q;
  assign key_state = key_state_q;
  assign any_key   = any_key_q;
  assign key_press = key_press_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: ideal keypad model plus a scan-level
// debounce reference model driven by directed and random key patterns.
module tb_keypad_scanner;

  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] key_state;
  logic        any_key;
  logic        key_press;
  logic [3:0]  key_code;

  logic [15:0] held = '0;

  int total = 0;
  int bad = 0;

  logic [15:0] m_cand;
  int          m_cnt;
  logic [15:0] m_ks;
  logic        exp_press;
  logic [3:0]  exp_code;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .col_n(col_n),
    .row_n(row_n), .key_state(key_state), .any_key(any_key),
    .key_press(key_press), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // A held key shorts its row to its column while that row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && held[4*r+c]) col_n[c] = 1'b0;
  end

  task automatic model_reset();
    m_cand = '0;
    m_cnt = 0;
    m_ks = 16'hFFFF;
    exp_press = 1'b0;
    exp_code = '0;
  endtask

  task automatic model_step(input logic [15:0] mask);
    logic [15:0] snap, newk;
    snap = ~mask;
    if (snap == m_cand) begin
      if (m_cnt < DB) m_cnt++;
    end else begin
      m_cand = snap;
      m_cnt = 1;
    end
    exp_press = 1'b0;
    if (m_cnt >= DB) begin
      newk = m_ks & ~m_cand;
      if (newk != 0) begin
        exp_press = 1'b1;
        for (int i = 0; i < 16; i++)
          if (newk[i]) begin exp_code = 4'(i); break; end
      end
      m_ks = m_cand;
    end
  endtask

  task automatic start();
    @(negedge clk);
    rst_n = 1'b0;
    scan_en = 1'b0;
    held = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    scan_en = 1'b1;
  endtask

  // Runs one full scan with the given keys held, then checks the outputs just after EVAL.
  task automatic do_scan(input logic [15:0] mask, input string tag);
    bit seen;
    seen = 1'b0;
    held = mask;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_press !== 1'b0) begin
        total++; bad++;
        $display("[TB] FAIL %s stray_press got=%b want=0", tag, key_press);
      end
      if (row_n === 4'hF) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s scan_timeout got=no_eval want=eval", tag);
      return;
    end
    model_step(mask);
    @(negedge clk);
    total++;
    if (key_state !== m_ks) begin
      bad++; $display("[TB] FAIL %s key_state got=%h want=%h", tag, key_state, m_ks);
    end
    total++;
    if (any_key !== (m_ks != 16'hFFFF)) begin
      bad++; $display("[TB] FAIL %s any_key got=%b want=%b", tag, any_key, m_ks != 16'hFFFF);
    end
    total++;
    if (key_press !== exp_press) begin
      bad++; $display("[TB] FAIL %s key_press got=%b want=%b", tag, key_press, exp_press);
    end
    if (exp_press) begin
      total++;
      if (key_code !== exp_code) begin
        bad++; $display("[TB] FAIL %s key_code got=%0d want=%0d", tag, key_code, exp_code);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    start();
    repeat (2) do_scan(16'h0040, "reset_pre");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (row_n !== 4'hF) begin bad++; $display("[TB] FAIL rst_row_n got=%h want=f", row_n); end
    total++;
    if (key_state !== 16'hFFFF) begin bad++; $display("[TB] FAIL rst_key_state got=%h want=ffff", key_state); end
    total++;
    if (any_key !== 1'b0 || key_press !== 1'b0 || key_code !== 4'h0) begin
      bad++; $display("[TB] FAIL rst_flags got=%b%b%h want=000", any_key, key_press, key_code);
    end
    model_reset();
    @(negedge clk);
    scan_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== 4'hF) begin bad++; $display("[TB] FAIL idle_row_n got=%h want=f", row_n); end
    end
    scan_en = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 17; k++) begin
        @(negedge clk);
        exp_row = (k < 16) ? ~(4'b0001 << (k / 4)) : 4'hF;
        total++;
        if (row_n !== exp_row) begin
          bad++; $display("[TB] FAIL row_seq[%0d] got=%h want=%h", p*17+k, row_n, exp_row);
        end
      end
  endtask

  task automatic test_hold_release();
    start();
    repeat (4) do_scan(16'h0040, "hold6");
    repeat (3) do_scan(16'h0000, "release6");
  endtask

  task automatic test_alternate();
    start();
    for (int i = 0; i < 6; i++) do_scan((i % 2 == 0) ? 16'h0001 : 16'h0000, "alt0");
  endtask

  task automatic test_multi();
    start();
    repeat (3) do_scan(16'h1008, "multi");
  endtask

  task automatic test_scan_en();
    bit seen;
    start();
    repeat (2) do_scan(16'h0040, "en_pre");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row_n === 4'hB) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL en_row2_timeout got=none want=b"); end
    scan_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== 4'hF || key_state !== 16'hFFBF) begin
        bad++; $display("[TB] FAIL en_park got=%h/%h want=f/ffbf", row_n, key_state);
      end
    end
    scan_en = 1'b1;
    @(negedge clk);
    total++;
    if (row_n !== 4'hE) begin bad++; $display("[TB] FAIL en_restart got=%h want=e", row_n); end
    repeat (2) do_scan(16'h0000, "en_release");
  endtask

  task automatic test_random();
    logic [15:0] mask;
    start();
    mask = '0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) != 0) mask = 16'($urandom & $urandom & $urandom);
      do_scan(mask, "random");
    end
  endtask

  initial begin
    test_reset();
    test_hold_release();
    test_alternate();
    test_multi();
    test_scan_en();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
